lsq_mem_arbiter: RTL
====================

# lsq_mem_arbiter

Sequences the single data-memory port shared by the load queue and the store queue. Each cycle it picks at most one load or one committed store, drives the memory bus command, and tracks the one outstanding transaction. It returns load data to the CDB with the load's PRF destination tag and squashes in-flight load results on a mispredict. It sits between the LSQ and the memory/L1 interface.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive load grants tolerated while a store waits before the store is forced through.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ld_req_valid  in  1  LQ has a load with a valid address
- ld_req_addr  in  64  load address
- ld_req_tag  in  $clog2(`PRF_SIZE)  load destination PRF tag
- ld_req_grant  out  1  load accepted this cycle; LQ dequeues it
- st_req_valid  in  1  SQ head store is committed and ready
- st_req_addr  in  64  store address
- st_req_data  in  64  store data
- st_req_grant  out  1  store accepted this cycle; SQ advances its head
- sq_almost_full  in  1  forces store priority
- mispredict  in  1  squash any in-flight load result
- mem_command  out  2  BUS_NONE / BUS_LOAD / BUS_STORE
- mem_addr  out  64  bus address
- mem_data  out  64  store data on the bus
- mem_ack  in  1  memory accepted the command
- mem_resp_valid  in  1  load response data is valid
- mem_resp_data  in  64  load response data
- lsq_CDB_result_is_valid  out  1  load result broadcast
- lsq_CDB_dest_tag  out  $clog2(`PRF_SIZE)  tag of the broadcast
- lsq_CDB_result_out  out  64  loaded value
- busy  out  1  state is not IDLE

## Operation
FSM states: IDLE, ISSUE, WAIT_LD.

- **IDLE**
  - Grants are combinational and mutually exclusive.
  - Store is chosen if st_req_valid and any of: !ld_req_valid, sq_almost_full, or starve_cnt ≥ STARVE_LIMIT. Otherwise a valid load is chosen.
  - On a grant, the address, data, tag and type are latched at the clock edge, and the FSM goes to ISSUE.
- **starve_cnt**
  - Increments on a load grant while st_req_valid is high, saturating at STARVE_LIMIT.
  - Clears on any store grant.
- **ISSUE**
  - mem_command is BUS_LOAD or BUS_STORE; mem_addr and mem_data come from the latch. These hold stable until mem_ack.
  - On mem_ack with a store, go to IDLE; the store is complete.
  - On mem_ack with a load, go to WAIT_LD.
- **WAIT_LD**
  - mem_command is BUS_NONE.
  - On mem_resp_valid, register the result. lsq_CDB_result_is_valid is 1 for one cycle, with the latched tag and mem_resp_data, unless squash is set. Then go to IDLE.
- **Mispredict**
  - mispredict while a load is in ISSUE or WAIT_LD sets squash. The bus transaction still completes, because a command cannot be retracted, but no CDB broadcast is made.
  - Stores are never squashed, since they are already committed.
  - squash clears on return to IDLE.
  - mispredict in IDLE only blocks that cycle's load grant; stores may still be granted.
- mem_resp_valid outside WAIT_LD is ignored.
- mem_ack outside ISSUE is ignored.

## Timing
- Reset values: state IDLE, starve_cnt 0, squash 0, both grants 0, mem_command BUS_NONE, mem_addr/mem_data 0, all CDB outputs 0, busy 0.
- Reset mid-transaction abandons the transaction immediately. No response is broadcast afterward.
- Grant in cycle T puts the command on the bus in T+1.
- A store with ack in T+1 is back in IDLE at T+2, which is also the earliest next grant.
- Load latency: a response in cycle R broadcasts on the CDB in R+1. The FSM is in IDLE in R+1, so a new grant is possible in that same cycle.
- Minimum load occupancy is 3 cycles (ISSUE, WAIT_LD, then IDLE).

## Configuration
- LSQ_ARB_STARVE_EN
  - Defined: the starvation counter and forced-store rule are active as described.
  - Undefined: no counter; loads always win unless sq_almost_full is high, and STARVE_LIMIT is unused.

## Test plan
- **Single store:** st_req_valid, addr 0x100, data 0xDEAD. Required: st_req_grant at T; BUS_STORE/0x100/0xDEAD at T+1; mem_ack at T+1; IDLE at T+2; no CDB broadcast.
- **Single load:** tag 7, addr 0x200. Required: BUS_LOAD at T+1 held until ack at T+3; mem_resp_valid with 0x55 at T+5; CDB valid, tag 7, data 0x55 at T+6 only.
- **Contention:** both requests valid, sq_almost_full 0. Required: load wins. With sq_almost_full 1, the store wins.
- **Starvation (macro defined):** continuous loads with a pending store, STARVE_LIMIT 4. Required: grant sequence L,L,L,L,S, and starve_cnt returns to 0. With the macro undefined, loads only.
- **Mispredict:** mispredict during WAIT_LD. Required: the response is consumed, no CDB valid, then IDLE. The same check applies with mispredict asserted while ISSUE waits for ack.
- **Async reset:** reset asserted in WAIT_LD. Required: outputs go to reset values without waiting for a clock edge; a later mem_resp_valid produces no broadcast.

Source files
------------

// File: rtl/lsq_mem_arbiter_if.sv
// Signal bundle between the LSQ, the shared data-memory port and the CDB.
// The arbiter uses the master modport; the LSQ/memory side uses the slave modport.
`ifndef PRF_SIZE
`define PRF_SIZE 32
`endif

interface lsq_mem_arbiter_if;
    localparam int TAG_W = $clog2(`PRF_SIZE);

    logic             ld_req_valid;
    logic [63:0]      ld_req_addr;
    logic [TAG_W-1:0] ld_req_tag;
    logic             ld_req_grant;

    logic             st_req_valid;
    logic [63:0]      st_req_addr;
    logic [63:0]      st_req_data;
    logic             st_req_grant;
    logic             sq_almost_full;

    logic             mispredict;

    logic [1:0]       mem_command;
    logic [63:0]      mem_addr;
    logic [63:0]      mem_data;
    logic             mem_ack;
    logic             mem_resp_valid;
    logic [63:0]      mem_resp_data;

    logic             lsq_CDB_result_is_valid;
    logic [TAG_W-1:0] lsq_CDB_dest_tag;
    logic [63:0]      lsq_CDB_result_out;
    logic             busy;

    modport master (
        input  ld_req_valid, ld_req_addr, ld_req_tag,
        output ld_req_grant,
        input  st_req_valid, st_req_addr, st_req_data, sq_almost_full,
        output st_req_grant,
        input  mispredict,
        output mem_command, mem_addr, mem_data,
        input  mem_ack, mem_resp_valid, mem_resp_data,
        output lsq_CDB_result_is_valid, lsq_CDB_dest_tag, lsq_CDB_result_out, busy
    );

    modport slave (
        output ld_req_valid, ld_req_addr, ld_req_tag,
        input  ld_req_grant,
        output st_req_valid, st_req_addr, st_req_data, sq_almost_full,
        input  st_req_grant,
        output mispredict,
        input  mem_command, mem_addr, mem_data,
        output mem_ack, mem_resp_valid, mem_resp_data,
        input  lsq_CDB_result_is_valid, lsq_CDB_dest_tag, lsq_CDB_result_out, busy
    );
endinterface

// File: rtl/lsq_mem_arbiter.sv
// Arbitrates the single data-memory port between load and store queues, tracks one
// outstanding transaction and broadcasts load results. Define LSQ_ARB_STARVE_EN for store anti-starvation.
`ifndef PRF_SIZE
`define PRF_SIZE 32
`endif

module lsq_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic              clock,
    input logic              reset,
    lsq_mem_arbiter_if.master bus
);
    localparam int TAG_W = $clog2(`PRF_SIZE);
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LD} state_t;

    state_t           state, next_state;
    logic [63:0]      lat_addr;
    logic [63:0]      lat_data;
    logic [TAG_W-1:0] lat_tag;
    logic             lat_is_load;
    logic             squash;
    logic             ld_grant, st_grant;
    logic             load_ok, store_pick, starve_hit;
    logic             resp_fire, broadcast;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [63:0]      cdb_data;

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be at least 1");
    end

`ifdef LSQ_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (st_grant)
            starve_cnt <= '0;
        else if (ld_grant && bus.st_req_valid && starve_cnt < CNT_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign starve_hit = (starve_cnt >= CNT_W'(STARVE_LIMIT));
`else
    assign starve_hit = 1'b0;
`endif

    // A mispredict in IDLE only suppresses the load; a committed store can still go.
    assign load_ok    = bus.ld_req_valid && !bus.mispredict;
    assign store_pick = bus.st_req_valid && (!load_ok || bus.sq_almost_full || starve_hit);

    always_comb begin
        next_state = state;
        ld_grant   = 1'b0;
        st_grant   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (store_pick)
                        st_grant = 1'b1;
                    else if (load_ok)
                        ld_grant = 1'b1;
                    if (store_pick || load_ok)
                        next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ack)
                    next_state = lat_is_load ? WAIT_LD : IDLE;
            end
            WAIT_LD: begin
                if (bus.mem_resp_valid)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_tag     <= '0;
            lat_is_load <= 1'b0;
        end else if (st_grant) begin
            lat_addr    <= bus.st_req_addr;
            lat_data    <= bus.st_req_data;
            lat_is_load <= 1'b0;
        end else if (ld_grant) begin
            lat_addr    <= bus.ld_req_addr;
            lat_data    <= '0;
            lat_tag     <= bus.ld_req_tag;
            lat_is_load <= 1'b1;
        end
    end

    // The bus command cannot be retracted, so a squashed load still runs to completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            squash <= 1'b0;
        else if (next_state == IDLE)
            squash <= 1'b0;
        else if (bus.mispredict && lat_is_load && state != IDLE)
            squash <= 1'b1;
    end

    assign resp_fire = (state == WAIT_LD) && bus.mem_resp_valid;
    assign broadcast = resp_fire && !squash && !bus.mispredict;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= broadcast;
            if (broadcast) begin
                cdb_tag  <= lat_tag;
                cdb_data <= bus.mem_resp_data;
            end
        end
    end

    always_comb begin
        bus.mem_command = BUS_NONE;
        if (state == ISSUE)
            bus.mem_command = lat_is_load ? BUS_LOAD : BUS_STORE;
    end

    assign bus.ld_req_grant            = ld_grant;
    assign bus.st_req_grant            = st_grant;
    assign bus.mem_addr                = lat_addr;
    assign bus.mem_data                = lat_data;
    assign bus.lsq_CDB_result_is_valid = cdb_valid;
    assign bus.lsq_CDB_dest_tag        = cdb_tag;
    assign bus.lsq_CDB_result_out      = cdb_data;
    assign bus.busy                    = (state != IDLE);
endmodule
